// File: rtl/chip8_sound_ctrl_if.sv
// rtl/chip8_sound_ctrl_if.sv - CPU/MMIO-side and audio-side signal bundle for chip8_sound_ctrl
interface chip8_sound_ctrl_if;
    logic       st_wr_in;
    logic [7:0] st_data_in;
    logic       pause_in;
    logic       cfg_wr_in;
    logic [1:0] cfg_addr_in;
    logic [9:0] cfg_data_in;
    logic [7:0] st_out;
    logic       tick_out;
    logic       active_out;
    logic [1:0] timbre_out;
    logic [9:0] tone_out;
    logic [7:0] vol_out;

    modport master (
        output st_wr_in, st_data_in, pause_in, cfg_wr_in, cfg_addr_in, cfg_data_in,
        input  st_out, tick_out, active_out, timbre_out, tone_out, vol_out
    );

    modport slave (
        input  st_wr_in, st_data_in, pause_in, cfg_wr_in, cfg_addr_in, cfg_data_in,
        output st_out, tick_out, active_out, timbre_out, tone_out, vol_out
    );
endinterface

// File: rtl/chip8_sound_ctrl.sv
// rtl/chip8_sound_ctrl.sv - CHIP-8 sound timer, 60 Hz tick and attack/release envelope sequencer
module chip8_sound_ctrl #(
    parameter int         TICK_PERIOD = 1666667,
    parameter int         ENV_PERIOD  = 65536,
    parameter logic [9:0] TONE_RESET  = 10'd256
) (
    input  logic               clk_in,
    input  logic               rst_in,
    chip8_sound_ctrl_if.slave  bus
);
    localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int EW = (ENV_PERIOD > 1) ? $clog2(ENV_PERIOD) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [EW-1:0] ENV_LAST  = EW'(ENV_PERIOD - 1);
    localparam logic [EW-1:0] ENV_ONE   = EW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [TW-1:0] r_tick_cnt;
    logic          r_tick;
    logic [7:0]    r_st;

    logic [1:0]    r_timbre_stg;
    logic [9:0]    r_tone_stg;
    logic [2:0]    r_vol_tgt;
    logic          r_env_en;

    logic [1:0]    r_timbre_hold;
    logic [9:0]    r_tone_hold;

    state_t        r_state;
    logic [2:0]    r_level;
    logic [EW-1:0] r_env_cnt;

    state_t        w_state_nxt;
    logic [2:0]    w_level_nxt;
    logic [EW-1:0] w_env_cnt_nxt;

    logic          w_st_zero;
    logic          w_env_wrap;
    logic [EW-1:0] w_env_cnt_inc;
    logic          w_copy;
    logic [1:0]    w_timbre;
    logic [9:0]    w_tone;

    // Free-running 60 Hz divider; the pulse is registered so it lands one cycle after the terminal count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick     <= (r_tick_cnt == TICK_LAST);
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_ONE;
        end
    end

    // Sound timer: a CPU load beats a coincident tick, and the count saturates at zero
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_st <= 8'd0;
        end else if (bus.st_wr_in) begin
            r_st <= bus.st_data_in;
        end else if (r_tick && !bus.pause_in && (r_st != 8'd0)) begin
            r_st <= r_st - 8'd1;
        end
    end

    // Configuration registers; tone and timbre are only staged here and released to the audio block later
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_timbre_stg <= 2'd0;
            r_tone_stg   <= TONE_RESET;
            r_vol_tgt    <= 3'd7;
            r_env_en     <= 1'b1;
        end else if (bus.cfg_wr_in) begin
            case (bus.cfg_addr_in)
                2'd0:    r_timbre_stg <= bus.cfg_data_in[1:0];
                2'd1:    r_tone_stg   <= bus.cfg_data_in;
                2'd2:    r_vol_tgt    <= bus.cfg_data_in[2:0];
                default: r_env_en     <= bus.cfg_data_in[0];
            endcase
        end
    end

    // Staged tone/timbre reach the audio block only on a tick boundary or while silent, so a
    // mid-note write never produces a partial-period glitch
    assign w_copy   = r_tick || (r_state == S_IDLE);
    assign w_timbre = w_copy ? r_timbre_stg : r_timbre_hold;
    assign w_tone   = w_copy ? r_tone_stg   : r_tone_hold;

    // Remember what was last presented so the outputs hold between copy points
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_timbre_hold <= 2'd0;
            r_tone_hold   <= TONE_RESET;
        end else begin
            r_timbre_hold <= w_timbre;
            r_tone_hold   <= w_tone;
        end
    end

    // Envelope state, level and step counter
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_level   <= 3'd0;
            r_env_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_env_cnt <= w_env_cnt_nxt;
        end
    end

    assign w_st_zero     = (r_st == 8'd0);
    assign w_env_wrap    = (r_env_cnt == ENV_LAST);
    assign w_env_cnt_inc = w_env_wrap ? '0 : r_env_cnt + ENV_ONE;

    // Envelope next-state: linear ramp up to the target, hold, linear ramp down; env_en only matters at transitions
    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_env_cnt_nxt = r_env_cnt;
        case (r_state)
            S_IDLE: begin
                w_level_nxt   = 3'd0;
                w_env_cnt_nxt = '0;
                if (!w_st_zero) begin
                    if (r_env_en) begin
                        w_state_nxt = S_ATTACK;
                    end else begin
                        w_state_nxt = S_SUSTAIN;
                        w_level_nxt = r_vol_tgt;
                    end
                end
            end
            S_ATTACK: begin
                if (w_st_zero) begin
                    w_state_nxt   = S_RELEASE;
                    w_env_cnt_nxt = '0;
                end else if (r_level >= r_vol_tgt) begin
                    // Target may have been lowered below the ramp; snap to it rather than overshoot
                    w_state_nxt = S_SUSTAIN;
                    w_level_nxt = r_vol_tgt;
                end else begin
                    w_env_cnt_nxt = w_env_cnt_inc;
                    if (w_env_wrap) begin
                        w_level_nxt = r_level + 3'd1;
                    end
                end
            end
            S_SUSTAIN: begin
                w_level_nxt = r_vol_tgt;
                if (w_st_zero) begin
                    if (r_env_en) begin
                        w_state_nxt   = S_RELEASE;
                        w_env_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_level_nxt = 3'd0;
                    end
                end
            end
            S_RELEASE: begin
                if (!w_st_zero) begin
                    // Reload mid-release ramps back up from wherever the level currently is
                    w_state_nxt   = S_ATTACK;
                    w_env_cnt_nxt = '0;
                end else if (r_level == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_env_cnt_nxt = w_env_cnt_inc;
                    if (w_env_wrap) begin
                        w_level_nxt = r_level - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_level_nxt   = 3'd0;
                w_env_cnt_nxt = '0;
            end
        endcase
    end

    // Audio stays enabled even at level 0: volume 0 still leaks LSB noise, so only IDLE truly mutes
    assign bus.st_out     = r_st;
    assign bus.tick_out   = r_tick;
    assign bus.active_out = (r_state != S_IDLE);
    assign bus.timbre_out = w_timbre;
    assign bus.tone_out   = w_tone;
    assign bus.vol_out    = {5'd0, r_level};
endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// tb/tb_chip8_sound_ctrl.sv - scoreboard testbench for chip8_sound_ctrl
module tb_chip8_sound_ctrl;
    localparam int SIG_ST     = 0;
    localparam int SIG_TICK   = 1;
    localparam int SIG_ACT    = 2;
    localparam int SIG_VOL    = 3;
    localparam int SIG_TONE   = 4;
    localparam int SIG_TIMBRE = 5;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_in;

    chip8_sound_ctrl_if bus();

    chip8_sound_ctrl #(
        .TICK_PERIOD (10),
        .ENV_PERIOD  (4),
        .TONE_RESET  (10'd256)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_abs  = 0;
    int   base     = 0;
    bit   started  = 1'b0;

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    function automatic int cur();
        return cyc_abs - base;
    endfunction

    function automatic int actual(input int sig);
        case (sig)
            SIG_ST:     return int'(bus.st_out);
            SIG_TICK:   return int'(bus.tick_out);
            SIG_ACT:    return int'(bus.active_out);
            SIG_VOL:    return int'(bus.vol_out);
            SIG_TONE:   return int'(bus.tone_out);
            default:    return int'(bus.timbre_out);
        endcase
    endfunction

    task automatic push(input int c, input int s, input int v, input string n);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.nm  = n;
        sb.push_back(e);
    endtask

    // Monitor: every cycle, pop and compare whatever the scoreboard expects at this cycle
    always @(negedge clk) begin
        int now;
        int a;
        if (started) begin
            now = cur();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= now) begin
                    checks++;
                    a = actual(sb[i].sig);
                    if (sb[i].cyc < now || a != sb[i].val) begin
                        failures++;
                        $display("FAIL %s @cycle %0d: got %0d expected %0d", sb[i].nm, sb[i].cyc, a, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cur() < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic st_write(input int c, input int d);
        wait_until(c);
        bus.st_wr_in   = 1'b1;
        bus.st_data_in = 8'(d);
        @(posedge clk);
        #1;
        bus.st_wr_in = 1'b0;
    endtask

    task automatic cfg_write(input int c, input int addr, input int d);
        wait_until(c);
        bus.cfg_wr_in   = 1'b1;
        bus.cfg_addr_in = 2'(addr);
        bus.cfg_data_in = 10'(d);
        @(posedge clk);
        #1;
        bus.cfg_wr_in = 1'b0;
    endtask

    initial begin
        rst_in          = 1'b1;
        bus.st_wr_in    = 1'b0;
        bus.st_data_in  = 8'd0;
        bus.pause_in    = 1'b0;
        bus.cfg_wr_in   = 1'b0;
        bus.cfg_addr_in = 2'd0;
        bus.cfg_data_in = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_in  = 1'b0;
        base    = cyc_abs;
        started = 1'b1;

        checks++;
        if (bus.st_out !== 8'd0) begin
            failures++;
            $display("FAIL direct_rst_st: got %0d expected 0", bus.st_out);
        end
        checks++;
        if (bus.active_out !== 1'b0) begin
            failures++;
            $display("FAIL direct_rst_active: got %0d expected 0", bus.active_out);
        end
        checks++;
        if (bus.vol_out !== 8'd0) begin
            failures++;
            $display("FAIL direct_rst_vol: got %0d expected 0", bus.vol_out);
        end
        checks++;
        if (bus.tone_out !== 10'd256) begin
            failures++;
            $display("FAIL direct_rst_tone: got %0d expected 256", bus.tone_out);
        end
        checks++;
        if (bus.timbre_out !== 2'd0) begin
            failures++;
            $display("FAIL direct_rst_timbre: got %0d expected 0", bus.timbre_out);
        end

        // Reset state and tick cadence
        push(0,  SIG_ST, 0, "rst_st");       push(0,  SIG_ACT, 0, "rst_active");
        push(0,  SIG_VOL, 0, "rst_vol");     push(0,  SIG_TONE, 256, "rst_tone");
        push(0,  SIG_TIMBRE, 0, "rst_timbre"); push(0, SIG_TICK, 0, "rst_tick");
        push(9,  SIG_TICK, 0, "tick_pre1");  push(10, SIG_TICK, 1, "tick_1");
        push(11, SIG_TICK, 0, "tick_post1"); push(19, SIG_TICK, 0, "tick_pre2");
        push(20, SIG_TICK, 1, "tick_2");     push(21, SIG_TICK, 0, "tick_post2");
        // Countdown with envelope disabled, target 5
        push(23, SIG_ST, 3, "cd_load");      push(23, SIG_ACT, 0, "cd_act_lat");
        push(24, SIG_ACT, 1, "cd_act");      push(24, SIG_VOL, 5, "cd_vol");
        push(30, SIG_ST, 3, "cd_st_tick");   push(31, SIG_ST, 2, "cd_st2");
        push(41, SIG_ST, 1, "cd_st1");       push(51, SIG_ST, 0, "cd_st0");
        push(51, SIG_ACT, 1, "cd_act_last"); push(52, SIG_ACT, 0, "cd_act_off");
        push(52, SIG_VOL, 0, "cd_vol_off");
        // Envelope attack/sustain/release, target 3
        push(56, SIG_ST, 10, "env_load");    push(57, SIG_ACT, 1, "env_act");
        push(57, SIG_VOL, 0, "att_l0a");     push(60, SIG_VOL, 0, "att_l0b");
        push(61, SIG_VOL, 1, "att_l1a");     push(64, SIG_VOL, 1, "att_l1b");
        push(65, SIG_VOL, 2, "att_l2a");     push(68, SIG_VOL, 2, "att_l2b");
        push(69, SIG_VOL, 3, "att_l3");      push(72, SIG_VOL, 3, "sus_l3");
        push(151, SIG_ST, 0, "env_st0");     push(151, SIG_ACT, 1, "env_act_sus");
        push(152, SIG_VOL, 3, "rel_l3a");    push(155, SIG_VOL, 3, "rel_l3b");
        push(156, SIG_VOL, 2, "rel_l2a");    push(159, SIG_VOL, 2, "rel_l2b");
        push(160, SIG_VOL, 1, "rel_l1a");    push(161, SIG_ST, 0, "st0_tick_hold");
        push(163, SIG_VOL, 1, "rel_l1b");    push(164, SIG_VOL, 0, "rel_l0");
        push(164, SIG_ACT, 1, "rel_act_l0"); push(165, SIG_ACT, 0, "rel_idle");
        // Reload during release
        push(167, SIG_ST, 2, "rl_load");     push(168, SIG_ACT, 1, "rl_act");
        push(168, SIG_VOL, 0, "rl_att0");    push(171, SIG_ST, 1, "rl_st1");
        push(176, SIG_VOL, 2, "rl_att2");    push(181, SIG_ST, 0, "rl_st0");
        push(182, SIG_VOL, 3, "rl_rel3");    push(186, SIG_VOL, 2, "rl_rel2");
        push(188, SIG_ST, 5, "rl_reload");   push(188, SIG_VOL, 2, "rl_rel2b");
        push(189, SIG_VOL, 2, "rl_att_from2"); push(189, SIG_ACT, 1, "rl_act2");
        push(190, SIG_VOL, 2, "rl_att_hold2"); push(191, SIG_ST, 4, "rl_st4");
        push(192, SIG_VOL, 2, "rl_att2_end"); push(193, SIG_VOL, 3, "rl_att3");
        // Collisions and pause
        push(196, SIG_ST, 7, "col_load7");   push(200, SIG_ST, 7, "col_st7");
        push(200, SIG_TICK, 1, "col_tick");  push(201, SIG_ST, 20, "col_wr_wins");
        push(211, SIG_ST, 20, "pause_t1");   push(221, SIG_ST, 20, "pause_t2");
        push(231, SIG_ST, 20, "pause_t3");   push(241, SIG_ST, 19, "unpause_dec");
        // Glitch-free tone/timbre while active; unused data bits ignored
        push(244, SIG_TONE, 256, "tone_hold_a"); push(249, SIG_TONE, 256, "tone_hold_b");
        push(250, SIG_TONE, 500, "tone_tick");   push(251, SIG_TONE, 500, "tone_after");
        push(249, SIG_TIMBRE, 0, "timbre_hold"); push(250, SIG_TIMBRE, 2, "timbre_tick");
        push(253, SIG_VOL, 3, "vt_before");      push(254, SIG_VOL, 2, "vt_track");
        push(254, SIG_ACT, 1, "vt_act");
        // Mid-operation reset, then IDLE tone update and reset vol_target
        push(257, SIG_ST, 40, "mr_load");    push(260, SIG_ACT, 1, "mr_act_pre");
        push(261, SIG_ST, 0, "mr_st");       push(261, SIG_ACT, 0, "mr_act");
        push(261, SIG_VOL, 0, "mr_vol");     push(261, SIG_TONE, 256, "mr_tone");
        push(261, SIG_TIMBRE, 0, "mr_timbre"); push(261, SIG_TICK, 0, "mr_tick");
        push(262, SIG_TONE, 300, "idle_tone"); push(264, SIG_ST, 2, "mr2_load");
        push(264, SIG_VOL, 0, "mr2_vol0");   push(265, SIG_VOL, 7, "mr2_vt7");
        push(265, SIG_ACT, 1, "mr2_act");    push(270, SIG_TICK, 0, "mr_tick_pre");
        push(271, SIG_TICK, 1, "mr_tick_first");

        cfg_write(1, 3, 0);
        cfg_write(2, 2, 5);
        st_write(22, 3);
        cfg_write(53, 3, 1);
        cfg_write(54, 2, 3);
        st_write(55, 10);
        st_write(166, 2);
        st_write(187, 5);
        st_write(195, 7);
        st_write(200, 20);
        wait_until(201);
        bus.pause_in = 1'b1;
        wait_until(231);
        bus.pause_in = 1'b0;
        cfg_write(243, 1, 500);
        cfg_write(244, 0, 10'h3F6);
        cfg_write(252, 2, 10'h3FA);
        st_write(256, 40);
        wait_until(260);
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        cfg_write(261, 1, 300);
        cfg_write(262, 3, 0);
        st_write(263, 2);
        wait_until(275);

        while (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: never compared, expected %0d at cycle %0d", sb[0].nm, sb[0].val, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
